// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell walked LSB-first over WIDTH cycles.
// Computes diff = a - b - bin (mod 2^WIDTH) with a final borrow-out, start/done handshake.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             bout_q, bout_d;

  logic             d_bit, c_nxt;
  logic [WIDTH-1:0] r_next;

  assign d_bit = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & c_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    bout_d  = bout_q;
    // Difference bits enter from the MSB so the LSB lands at bit 0 after WIDTH shifts.
    r_next            = r_sh_q >> 1;
    r_next[WIDTH-1]   = d_bit;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_sh_d = r_next;
        c_d    = c_nxt;
        if (cnt_q == CNT_LAST) begin
          diff_d  = r_next;
          bout_d  = c_nxt;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
